// File: rtl/clb_scan_loader_if.sv
// Host-side port bundle for clb_scan_loader.
//   start/mode/abort    : operation control (master -> slave)
//   busy/done           : operation status (slave -> master)
//   wr_data/wr_valid/wr_ready : configuration words into the controller
//   rd_data/rd_valid/rd_ready : readback words out of the controller
// The master modport is the host view; the slave modport is the controller view.
interface clb_scan_loader_if #(
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic              mode;
    logic              abort;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        output start, mode, abort, wr_data, wr_valid, rd_ready,
        input  busy, done, wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  start, mode, abort, wr_data, wr_valid, rd_ready,
        output busy, done, wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/clb_scan_loader.sv
// Scan-chain configuration controller for one CLB.
// Write mode serializes host words LSB-first onto the chain; readback mode rotates the chain
// through itself (contents preserved) and returns the captured bits as host words.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   host        : control/status plus write and readback valid/ready ports (slave modport)
//   scan_en     : chain shift enable, high only while bits are moving
//   chain_sdo   : drives the chain's scan_in
//   chain_sdi   : from the chain's scan_out
module clb_scan_loader #(
    parameter int unsigned CHAIN_LEN = 29,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    clb_scan_loader_if.slave    host,
    output logic                scan_en,
    output logic                chain_sdo,
    input  logic                chain_sdi
);

    localparam int unsigned WCNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_B = CNT_W'(CHAIN_LEN);
    localparam logic [WCNT_W-1:0] LAST_W = WCNT_W'(DATA_W);

    typedef enum logic [2:0] {
        StIdle,
        StWrWait,
        StWrShift,
        StRdShift,
        StRdOut,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bcnt_q, bcnt_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   sbuf_q, sbuf_d;
    logic [DATA_W-1:0]   rbuf_q, rbuf_d;
    logic [CNT_W-1:0]    bcnt_inc;
    logic [WCNT_W-1:0]   wcnt_inc;

    assign bcnt_inc = bcnt_q + 1'b1;
    assign wcnt_inc = wcnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        bcnt_d        = bcnt_q;
        wcnt_d        = wcnt_q;
        sbuf_d        = sbuf_q;
        rbuf_d        = rbuf_q;
        scan_en       = 1'b0;
        chain_sdo     = 1'b0;
        host.busy     = (state_q != StIdle);
        host.done     = 1'b0;
        host.wr_ready = 1'b0;
        host.rd_valid = 1'b0;
        host.rd_data  = '0;

        unique case (state_q)
            StIdle: begin
                if (host.start) begin
                    bcnt_d  = '0;
                    wcnt_d  = '0;
                    rbuf_d  = '0;
                    state_d = host.mode ? StRdShift : StWrWait;
                end
            end
            StWrWait: begin
                host.wr_ready = 1'b1;
                if (host.wr_valid) begin
                    sbuf_d  = host.wr_data;
                    wcnt_d  = '0;
                    state_d = StWrShift;
                end
            end
            StWrShift: begin
                scan_en   = 1'b1;
                chain_sdo = sbuf_q[0];
                sbuf_d    = sbuf_q >> 1;
                bcnt_d    = bcnt_inc;
                wcnt_d    = wcnt_inc;
                // Chain end wins over word end: unused upper bits of the last word are dropped.
                if (bcnt_inc == LAST_B) begin
                    state_d = StDone;
                end else if (wcnt_inc == LAST_W) begin
                    state_d = StWrWait;
                end
            end
            StRdShift: begin
                scan_en   = 1'b1;
                chain_sdo = chain_sdi;  // rotate so the chain keeps its contents
                rbuf_d    = rbuf_q | (DATA_W'(chain_sdi) << wcnt_q);
                bcnt_d    = bcnt_inc;
                wcnt_d    = wcnt_inc;
                if (wcnt_inc == LAST_W || bcnt_inc == LAST_B) begin
                    state_d = StRdOut;
                end
            end
            StRdOut: begin
                host.rd_valid = 1'b1;
                host.rd_data  = rbuf_q;
                if (host.rd_ready) begin
                    if (bcnt_q == LAST_B) begin
                        state_d = StDone;
                    end else begin
                        wcnt_d  = '0;
                        rbuf_d  = '0;
                        state_d = StRdShift;
                    end
                end
            end
            StDone: begin
                host.done = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (host.abort && state_q != StIdle) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            sbuf_q  <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            sbuf_q  <= sbuf_d;
            rbuf_q  <= rbuf_d;
        end
    end

endmodule

// File: tb/tb_clb_scan_loader.sv
module tb_clb_scan_loader;
    localparam int unsigned CHAIN_LEN = 29;
    localparam int unsigned DATA_W    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scan_en;
    logic chain_sdo;
    logic chain_sdi;

    clb_scan_loader_if #(.DATA_W(DATA_W)) host ();

    clb_scan_loader #(
        .CHAIN_LEN(CHAIN_LEN),
        .DATA_W   (DATA_W),
        .CNT_W    (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .host     (host),
        .scan_en  (scan_en),
        .chain_sdo(chain_sdo),
        .chain_sdi(chain_sdi)
    );

    always #5 clk = ~clk;

    // Chain model: scan_in enters at the top, scan_out is bit 0.
    logic [CHAIN_LEN-1:0] chain = '0;
    assign chain_sdi = chain[0];
    always @(posedge clk) begin
        if (scan_en) chain <= {chain_sdo, chain[CHAIN_LEN-1:1]};
    end

    int sen_cnt = 0;
    int done_cnt = 0;
    int sdo_viol = 0;
    always @(posedge clk) begin
        if (scan_en) sen_cnt <= sen_cnt + 1;
        if (host.done) done_cnt <= done_cnt + 1;
    end
    always @(negedge clk) begin
        if (!scan_en && chain_sdo) sdo_viol <= sdo_viol + 1;
    end

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [CHAIN_LEN-1:0] exp_chain;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (host.busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_idle_timeout"}, 32'(host.busy), 32'd0);
    endtask

    task automatic give_word(input logic [7:0] w, input int gap, input string tag);
        int t = 0;
        while (!host.wr_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_wr_ready_timeout"}, 32'(t < 100), 32'd1);
        for (int g = 0; g < gap; g++) begin
            check({tag, "_gap_scan_en"}, 32'(scan_en), 32'd0);
            check({tag, "_gap_wr_ready"}, 32'(host.wr_ready), 32'd1);
            @(negedge clk);
        end
        host.wr_data  = w;
        host.wr_valid = 1'b1;
        @(negedge clk);
        host.wr_valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] words, input int gap, input string tag);
        int s0 = sen_cnt;
        int d0 = done_cnt;
        @(negedge clk);
        host.start = 1'b1;
        host.mode  = 1'b0;
        @(negedge clk);
        host.start = 1'b0;
        for (int k = 0; k < 4; k++) give_word(words[8*k +: 8], (k > 0) ? gap : 0, tag);
        wait_idle(tag);
        check({tag, "_scan_cycles"}, 32'(sen_cnt - s0), CHAIN_LEN);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_chain"}, 32'(chain), 32'(exp_chain));
    endtask

    task automatic do_read(input int stall_word, input int stall_cyc, input bit poke_start,
                           input string tag);
        int s0 = sen_cnt;
        int d0 = done_cnt;
        int t;
        logic [31:0] tmp = 32'(exp_chain);
        for (int k = 0; k < 4; k++) exp_q.push_back(tmp[8*k +: 8]);
        @(negedge clk);
        host.start = 1'b1;
        host.mode  = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
        host.mode  = 1'b0;
        if (poke_start) begin
            @(negedge clk);
            @(negedge clk);
            host.start = 1'b1;  // must be ignored while busy
            @(negedge clk);
            host.start = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (!host.rd_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            check({tag, "_rd_valid_timeout"}, 32'(t < 100), 32'd1);
            if (k == stall_word) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    check({tag, "_stall_data"}, 32'(host.rd_data), 32'(exp_q[0]));
                    check({tag, "_stall_scan_en"}, 32'(scan_en), 32'd0);
                    @(negedge clk);
                end
            end
            host.rd_ready = 1'b1;
            check($sformatf("%s_word%0d", tag, k), 32'(host.rd_data), 32'(exp_q.pop_front()));
            @(negedge clk);
            host.rd_ready = 1'b0;
        end
        wait_idle(tag);
        check({tag, "_scan_cycles"}, 32'(sen_cnt - s0), CHAIN_LEN);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_chain_kept"}, 32'(chain), 32'(exp_chain));
    endtask

    initial begin
        int s0;
        int d0;
        int t;
        host.start    = 1'b0;
        host.mode     = 1'b0;
        host.abort    = 1'b0;
        host.wr_data  = '0;
        host.wr_valid = 1'b0;
        host.rd_ready = 1'b0;
        #1;
        check("rst_busy", 32'(host.busy), 32'd0);
        check("rst_wr_ready", 32'(host.wr_ready), 32'd0);
        check("rst_rd_valid", 32'(host.rd_valid), 32'd0);
        check("rst_scan_en", 32'(scan_en), 32'd0);
        check("rst_done", 32'(host.done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back write, then readbacks (plain, start ignored while busy, stalled).
        exp_chain = 29'h1BFF3CA5;
        do_write(32'h1BFF3CA5, 0, "wr_b2b");
        do_read(-1, 0, 1'b0, "rd_plain");
        do_read(-1, 0, 1'b1, "rd_start_busy");
        do_read(1, 5, 1'b0, "rd_stall");

        // Upper bits of the last word are dropped; readback pads them with zero.
        exp_chain = 29'h07563412;
        do_write(32'hE7563412, 3, "wr_trunc");
        do_read(-1, 0, 1'b0, "rd_trunc");

        // Abort at bit 12 of a write.
        s0 = sen_cnt;
        d0 = done_cnt;
        @(negedge clk);
        host.start = 1'b1;
        host.mode  = 1'b0;
        @(negedge clk);
        host.start = 1'b0;
        give_word(8'hA5, 0, "ab");
        give_word(8'h3C, 0, "ab");
        t = 0;
        while ((sen_cnt - s0) < 12 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("ab_bit12_timeout", 32'(t < 100), 32'd1);
        host.abort = 1'b1;
        @(negedge clk);
        host.abort = 1'b0;
        check("ab_busy", 32'(host.busy), 32'd0);
        check("ab_scan_en", 32'(scan_en), 32'd0);
        check("ab_wr_ready", 32'(host.wr_ready), 32'd0);
        @(negedge clk);
        check("ab_no_done", 32'(done_cnt - d0), 32'd0);

        // Fresh write after abort, with gaps: must match the back-to-back result.
        exp_chain = 29'h1BFF3CA5;
        do_write(32'h1BFF3CA5, 3, "wr_gap");
        do_read(-1, 0, 1'b0, "rd_gap");

        // Asynchronous reset in the middle of a readback.
        s0 = sen_cnt;
        @(negedge clk);
        host.start = 1'b1;
        host.mode  = 1'b1;
        @(negedge clk);
        host.start = 1'b0;
        host.mode  = 1'b0;
        t = 0;
        while ((sen_cnt - s0) < 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("mrst_busy_before", 32'(host.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(host.busy), 32'd0);
        check("mrst_scan_en", 32'(scan_en), 32'd0);
        check("mrst_sdo", 32'(chain_sdo), 32'd0);
        check("mrst_rd_valid", 32'(host.rd_valid), 32'd0);
        check("mrst_rd_data", 32'(host.rd_data), 32'd0);
        check("mrst_wr_ready", 32'(host.wr_ready), 32'd0);
        check("mrst_done", 32'(host.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("sdo_when_idle", 32'(sdo_viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clb_scan_loader.md
Name: clb_scan_loader

Overview:
- Configuration controller that sequences the serial scan chain of one CLB: the is_comb bit, the complete-connection mux selects and the LUT contents.
- Write mode: accepts configuration words from a host over a valid/ready port, serializes them LSB-first onto the chain and drives scan_en only while bits are moving.
- Readback mode: rotates the chain through itself, so configuration is preserved, and returns the captured bits as words over a valid/ready port.
- Sits between the device-level configuration port and each CLB's scan_in/scan_out pair.

Parameters:
- CHAIN_LEN, 29, total scan bits in the target chain (1 + 12 + 16 for the default CLB).
- DATA_W, 8, host word width.
- CNT_W, 16, width of the chain bit counter; must satisfy 2**CNT_W > CHAIN_LEN.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin operation; sampled only in IDLE.
- mode  input  1  0 = write, 1 = readback; sampled with start.
- abort  input  1  terminate the current operation.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at normal completion.
- wr_data  input  DATA_W  configuration word; bit 0 is shifted first.
- wr_valid  input  1  host word valid.
- wr_ready  output  1  controller can accept a word.
- rd_data  output  DATA_W  readback word.
- rd_valid  output  1  readback word valid.
- rd_ready  input  1  host accepts the readback word.
- scan_en  output  1  to the chain's scan_en.
- chain_sdo  output  1  to the chain's scan_in.
- chain_sdi  input  1  from the chain's scan_out.

Behaviour:
- Reset is asynchronous on rst_n low. Every output goes to 0 and the state goes to IDLE. Reset mid-operation leaves the chain partially shifted; no recovery is attempted.
- Bit counter bcnt counts 0..CHAIN_LEN-1. Word bit index wcnt counts 0..DATA_W-1.
- States: IDLE, WR_WAIT, WR_SHIFT, RD_SHIFT, RD_OUT, DONE.
- IDLE: when start=1, clear bcnt and wcnt. mode=0 goes to WR_WAIT; mode=1 goes to RD_SHIFT. start in any other state is ignored.
- WR_WAIT: wr_ready=1 and scan_en=0. On wr_valid&&wr_ready, load the shift buffer and go to WR_SHIFT next cycle.
- WR_SHIFT: scan_en=1 and chain_sdo=buf[0]. At each posedge the buffer shifts right and bcnt and wcnt increment.
  - bcnt reaching CHAIN_LEN goes to DONE; the unused upper bits of the last word are discarded.
  - Otherwise wcnt reaching DATA_W goes to WR_WAIT.
  - Throughput is DATA_W+1 cycles per word. wr_ready is 0 while shifting.
- RD_SHIFT: scan_en=1 and chain_sdo=chain_sdi (rotate). At each posedge chain_sdi is captured into rbuf[wcnt], then bcnt and wcnt increment.
  - Go to RD_OUT when wcnt reaches DATA_W or bcnt reaches CHAIN_LEN.
  - rbuf is cleared at each word start, so the pad bits of the final word read 0.
- RD_OUT: scan_en=0, rd_valid=1, rd_data=rbuf, held stable until rd_ready.
  - On handshake, if bcnt==CHAIN_LEN go to DONE, else clear wcnt and go to RD_SHIFT.
  - Backpressure stalls the chain with scan_en low; no bits are lost.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- After exactly CHAIN_LEN rotate shifts the chain holds its original contents.
- abort is checked in every non-IDLE state and has priority over all other events. Next cycle: IDLE, scan_en=0, wr_ready=0, rd_valid=0, done not pulsed.
- scan_en is never high in IDLE, WR_WAIT, RD_OUT or DONE. The total number of scan_en-high cycles per completed operation equals CHAIN_LEN exactly.
- chain_sdo is 0 whenever scan_en=0.

Test Plan:
- Write, CHAIN_LEN=29, DATA_W=8, words 0xA5,0x3C,0xFF,0x1B: exactly 29 scan_en cycles; the shifted bit stream equals the LSB-first concatenation truncated to 29 bits (bits 5-7 of 0x1B dropped); done pulses once; the chain model matches.
- Readback after that write: rd_data sequence 0xA5,0x3C,0xFF,0x1B with word 3 upper bits zero; chain contents unchanged afterwards; a second readback returns identical words.
- Readback with rd_ready held low for 5 cycles on word 1: rd_data stable and scan_en=0 during the stall; final words unchanged versus the no-stall run.
- Write with wr_valid gaps of 3 cycles between words: controller waits in WR_WAIT with scan_en=0; result identical to the back-to-back case.
- abort asserted at bit 12 of a write: next cycle busy=0 and scan_en=0, done stays 0; a following start, mode=0 loads correctly from bit 0.
- rst_n pulsed low mid-readback: all outputs 0 immediately (asynchronously); start asserted while busy is ignored (bcnt is not reset).
